// File: rtl/fork_join_sched.sv
// -----------------------------------------------------------------------------
// fork_join_sched
//
// Hardware scheduler for NUM_TASKS concurrent timed tasks with fork/join
// semantics. One accepted start launches every enabled task at once; each
// task stays active for its programmed number of cycles. The parent sequencer
// is released by join_o according to the captured mode:
//   00 join      - release when the last launched task completes
//   01 join_any  - release when the first launched task completes
//   10 join_none - release in the first cycle after the fork
//   11           - same as join
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   start_i        fork request, sampled on the rising edge
//   mode_i         join mode (see above), captured at accept only
//   enable_i       task mask, bit i launches task i, captured at accept only
//   dur_i          task i duration in [i*CNT_W +: CNT_W], 0 behaves as 1
//   task_active_o  task i running
//   task_done_o    one-cycle pulse in the last active cycle of task i
//   join_o         one-cycle pulse, parent may resume
//   all_done_o     one-cycle pulse in the cycle the last launched task ends
//   busy_o         scheduler not idle (from the cycle after accept through
//                  the last active cycle)
//   start_err_o    one-cycle pulse, a start arrived while not idle
//
// Timing model: if the fork is accepted at edge E0, the cycle following E0 is
// the first active cycle. Every output is a register, so each pulse is
// computed one edge ahead from the counters' current values.
// CNT_W must be at least 2.
// -----------------------------------------------------------------------------
module fork_join_sched #(
    parameter int NUM_TASKS = 3,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [1:0]                 mode_i,
    input  logic [NUM_TASKS-1:0]       enable_i,
    input  logic [NUM_TASKS*CNT_W-1:0] dur_i,
    output logic [NUM_TASKS-1:0]       task_active_o,
    output logic [NUM_TASKS-1:0]       task_done_o,
    output logic                       join_o,
    output logic                       all_done_o,
    output logic                       busy_o,
    output logic                       start_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_JOIN = 2'd1,
        ST_DETACHED  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ANY  = 2'b01;
    localparam logic [1:0] MODE_NONE = 2'b10;

    state_t     state_reg;
    logic [1:0] mode_reg;
    logic       join_reg;
    logic       all_done_reg;
    logic       busy_reg;
    logic       start_err_reg;

    logic       accept;

    // Per-task lookahead flags, one bit per task slot.
    //   accept_fin : task is launched now and its only cycle is the next one
    //   accept_run : task is launched now and lasts beyond the next cycle
    //   run_fin    : running task whose last cycle is the next one
    //   run_cont   : running task that is still active after the next cycle
    logic [NUM_TASKS-1:0] accept_fin;
    logic [NUM_TASKS-1:0] accept_run;
    logic [NUM_TASKS-1:0] run_fin;
    logic [NUM_TASKS-1:0] run_cont;
    logic [NUM_TASKS-1:0] active_vec;
    logic [NUM_TASKS-1:0] done_vec;

    assign accept = start_i && (state_reg == ST_IDLE);

    // -------------------------------------------------------------------------
    // Task slots. The counter holds the number of active cycles remaining,
    // including the current one, so a task in its last cycle reads 1 and the
    // slot about to finish reads 2.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_TASKS; gi++) begin : g_task
            logic [CNT_W-1:0] dur_slice;
            logic [CNT_W-1:0] eff_dur;
            logic [CNT_W-1:0] cnt_reg;
            logic             active_reg;
            logic             done_reg;

            assign dur_slice = dur_i[gi*CNT_W +: CNT_W];
            // A programmed duration of 0 still gives one active cycle.
            assign eff_dur   = (dur_slice == '0) ? CNT_W'(1) : dur_slice;

            assign accept_fin[gi] = enable_i[gi] && (eff_dur == CNT_W'(1));
            assign accept_run[gi] = enable_i[gi] && (eff_dur >  CNT_W'(1));
            assign run_fin[gi]    = active_reg && (cnt_reg == CNT_W'(2));
            assign run_cont[gi]   = active_reg && (cnt_reg >  CNT_W'(2));

            assign active_vec[gi] = active_reg;
            assign done_vec[gi]   = done_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    active_reg <= 1'b0;
                    done_reg   <= 1'b0;
                end else if (accept) begin
                    cnt_reg    <= enable_i[gi] ? eff_dur : '0;
                    active_reg <= enable_i[gi];
                    done_reg   <= accept_fin[gi];
                end else if (active_reg) begin
                    // Saturating decrement: the counter never wraps below 0.
                    cnt_reg    <= (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : '0;
                    active_reg <= (cnt_reg > CNT_W'(1));
                    done_reg   <= (cnt_reg == CNT_W'(2));
                end else begin
                    done_reg   <= 1'b0;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Completion lookahead shared by all modes.
    // launch_all_done: nothing launched outlives the first cycle (this covers
    //                  the empty mask as well as all-ones durations).
    // run_all_done   : at least one task finishes next cycle and none remains
    //                  beyond it.
    // -------------------------------------------------------------------------
    logic launch_all_done;
    logic launch_any_fin;
    logic run_all_done;
    logic run_any_fin;

    assign launch_all_done = (accept_run == '0);
    assign launch_any_fin  = (accept_fin != '0);
    assign run_any_fin     = (run_fin != '0);
    assign run_all_done    = run_any_fin && (run_cont == '0);

    // -------------------------------------------------------------------------
    // Control FSM with registered pulse outputs. The FSM stays out of IDLE
    // through the cycle in which all_done_o is high and returns to IDLE on the
    // following edge, so busy_o tracks "state is not IDLE" exactly.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= 2'b00;
            join_reg      <= 1'b0;
            all_done_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            start_err_reg <= 1'b0;
        end else begin
            join_reg      <= 1'b0;
            all_done_reg  <= 1'b0;
            start_err_reg <= start_i && (state_reg != ST_IDLE);

            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_reg     <= mode_i;
                        busy_reg     <= 1'b1;
                        all_done_reg <= launch_all_done;
                        case (mode_i)
                            MODE_NONE: begin
                                join_reg  <= 1'b1;
                                state_reg <= ST_DETACHED;
                            end
                            MODE_ANY: begin
                                join_reg  <= launch_any_fin || launch_all_done;
                                state_reg <= ST_WAIT_JOIN;
                            end
                            default: begin
                                join_reg  <= launch_all_done;
                                state_reg <= ST_WAIT_JOIN;
                            end
                        endcase
                    end
                end

                ST_WAIT_JOIN: begin
                    all_done_reg <= run_all_done;
                    if (all_done_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (mode_reg == MODE_ANY) begin
                        // The first completion releases the parent once;
                        // remaining tasks then run on detached.
                        if (join_reg) begin
                            state_reg <= ST_DETACHED;
                        end else begin
                            join_reg <= run_any_fin;
                        end
                    end else begin
                        join_reg <= run_all_done;
                    end
                end

                ST_DETACHED: begin
                    all_done_reg <= run_all_done;
                    if (all_done_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign task_active_o = active_vec;
    assign task_done_o   = done_vec;
    assign join_o        = join_reg;
    assign all_done_o    = all_done_reg;
    assign busy_o        = busy_reg;
    assign start_err_o   = start_err_reg;

endmodule

// File: tb/tb_fork_join_sched.sv
// -----------------------------------------------------------------------------
// Testbench for fork_join_sched (NUM_TASKS=3, CNT_W=8).
// Expected outputs for every cycle of a fork are derived in closed form from
// the accepted mode, mask and effective durations: with cycle k counted from
// the first cycle after the accepting edge, task i is active for k <= D_i,
// done at k == D_i, the fork ends at L = max D_i (1 for an empty mask), and
// join_any releases at F = min D_i.
// -----------------------------------------------------------------------------
module tb_fork_join_sched;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [2:0]  enable_i;
    logic [23:0] dur_i;
    logic [2:0]  task_active_o;
    logic [2:0]  task_done_o;
    logic        join_o;
    logic        all_done_o;
    logic        busy_o;
    logic        start_err_o;

    int checks   = 0;
    int failures = 0;
    int run_id   = 0;

    fork_join_sched #(
        .NUM_TASKS(3),
        .CNT_W(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .enable_i      (enable_i),
        .dur_i         (dur_i),
        .task_active_o (task_active_o),
        .task_done_o   (task_done_o),
        .join_o        (join_o),
        .all_done_o    (all_done_o),
        .busy_o        (busy_o),
        .start_err_o   (start_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s run=%0d cycle=%0d observed=%0h expected=%0h",
                   tag, run_id, cyc, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag, input int cyc);
        chk({tag, "_active"},   cyc, {5'd0, task_active_o}, 8'd0);
        chk({tag, "_done"},     cyc, {5'd0, task_done_o},   8'd0);
        chk({tag, "_join"},     cyc, {7'd0, join_o},        8'd0);
        chk({tag, "_all_done"}, cyc, {7'd0, all_done_o},    8'd0);
        chk({tag, "_busy"},     cyc, {7'd0, busy_o},        8'd0);
        chk({tag, "_start_err"},cyc, {7'd0, start_err_o},   8'd0);
    endtask

    // Called at a falling edge; launches a fork on the next rising edge (E0)
    // and checks every cycle up to and including L+1. Returns at a falling
    // edge with start_i low so the next call starts back-to-back.
    // rej > 0      : pulse start_i so it is sampled at edge E0+rej
    // abort_at > 0 : drop rst_n so it is sampled at edge E0+abort_at
    task automatic run_fork(input logic [1:0] mode, input logic [2:0] en,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input int rej_in,
                            input int abort_at);
        int d [3];
        int eff [3];
        int big_l;
        int first_f;
        int rej;
        logic [2:0] exp_act;
        logic [2:0] exp_done;
        logic       exp_join;

        d[0] = int'(d0);
        d[1] = int'(d1);
        d[2] = int'(d2);
        big_l   = 0;
        first_f = 1000;
        for (int i = 0; i < 3; i++) begin
            eff[i] = (d[i] == 0) ? 1 : d[i];
            if (en[i]) begin
                if (eff[i] > big_l)   big_l   = eff[i];
                if (eff[i] < first_f) first_f = eff[i];
            end
        end
        if (big_l == 0) begin
            big_l   = 1;
            first_f = 1;
        end
        rej = (rej_in > big_l) ? 0 : rej_in;

        run_id++;
        $display("run %0d mode=%0d en=%b dur=%0d/%0d/%0d rej=%0d abort=%0d L=%0d",
                 run_id, mode, en, d0, d1, d2, rej, abort_at, big_l);

        start_i  = 1'b1;
        mode_i   = mode;
        enable_i = en;
        dur_i    = {d2, d1, d0};
        @(posedge clk);

        for (int k = 1; k <= big_l + 1; k++) begin
            @(negedge clk);
            if (abort_at > 0 && k == abort_at + 1) begin
                // Reset sampled at E0+abort_at: everything quiet, no pulses.
                chk_all_zero("abort", k);
                rst_n = 1'b1;
                @(negedge clk);
                chk_all_zero("after_abort", k + 1);
                return;
            end

            for (int i = 0; i < 3; i++) begin
                exp_act[i]  = en[i] && (k <= eff[i]);
                exp_done[i] = en[i] && (k == eff[i]);
            end
            case (mode)
                2'b10:   exp_join = (k == 1);
                2'b01:   exp_join = (k == first_f);
                default: exp_join = (k == big_l);
            endcase

            chk("active",    k, {5'd0, task_active_o}, {5'd0, exp_act});
            chk("done",      k, {5'd0, task_done_o},   {5'd0, exp_done});
            chk("join",      k, {7'd0, join_o},        {7'd0, exp_join});
            chk("all_done",  k, {7'd0, all_done_o},    {7'd0, 1'(k == big_l)});
            chk("busy",      k, {7'd0, busy_o},        {7'd0, 1'(k <= big_l)});
            chk("start_err", k, {7'd0, start_err_o},
                {7'd0, 1'(rej > 0 && k == rej + 1)});

            if (k == 1) begin
                // Inputs after the accepting edge must have no effect.
                start_i  = 1'b0;
                mode_i   = 2'($urandom);
                enable_i = 3'($urandom);
                dur_i    = 24'($urandom);
            end
            if (rej > 0 && k == rej)     start_i = 1'b1;
            if (rej > 0 && k == rej + 1) start_i = 1'b0;
            if (abort_at > 0 && k == abort_at) rst_n = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] rmode;
        logic [2:0] ren;
        logic [7:0] r0, r1, r2;
        int         rrej;

        rst_n    = 1'b0;
        start_i  = 1'b0;
        mode_i   = 2'b00;
        enable_i = 3'b000;
        dur_i    = 24'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset", 0);
        rst_n = 1'b1;

        run_fork(2'b10, 3'b111, 8'd30, 8'd40, 8'd50, 0, 0);   // join_none
        run_fork(2'b01, 3'b111, 8'd30, 8'd40, 8'd50, 0, 0);   // join_any
        run_fork(2'b00, 3'b111, 8'd30, 8'd40, 8'd50, 10, 0);  // join + reject
        run_fork(2'b00, 3'b000, 8'd5,  8'd6,  8'd7,  0, 0);   // empty mask
        run_fork(2'b00, 3'b001, 8'd0,  8'd9,  8'd9,  0, 0);   // zero duration
        run_fork(2'b01, 3'b111, 8'd30, 8'd40, 8'd50, 0, 35);  // reset mid-run
        run_fork(2'b11, 3'b110, 8'd3,  8'd7,  8'd4,  2, 0);   // mode 11 = join
        run_fork(2'b01, 3'b101, 8'd6,  8'd1,  8'd6,  0, 0);   // simultaneous first
        run_fork(2'b10, 3'b000, 8'd0,  8'd0,  8'd0,  0, 0);   // join_none, empty
        run_fork(2'b01, 3'b011, 8'd1,  8'd1,  8'd9,  1, 0);   // all finish at once

        for (int n = 0; n < 10; n++) begin
            rmode = 2'($urandom_range(0, 3));
            ren   = 3'($urandom);
            r0    = 8'($urandom_range(0, 14));
            r1    = 8'($urandom_range(0, 14));
            r2    = 8'($urandom_range(0, 14));
            rrej  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 14) : 0;
            run_fork(rmode, ren, r0, r1, r2, rrej, 0);
        end

        @(negedge clk);
        chk_all_zero("final_idle", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
